// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run-control sequencer for the CPU core. Gates the core
//               clock-enable to RUN, single-STEP or STOP the core, writes
//               instruction memory while the core is stopped, stops on HALT,
//               PC breakpoint or user STOP, and keeps saturating cycle and
//               instruction counters.
// Ports       : clk/rst_n                   clock, async active-low reset
//               cmd_valid/cmd_ready/cmd_op  host command handshake
//               cmd_addr/cmd_data           LOAD address/data
//               cmd_err                     illegal-command pulse
//               cpu_en                      core clock-enable
//               cpu_halt/cpu_fetch/cpu_pc   core status inputs
//               bp_en/bp_addr               PC breakpoint
//               imem_we/imem_waddr/wdata    IMEM write port
//               state/stop_cause            sequencer status
//               cycle_cnt/instr_cnt         saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int CYC_W       = 16,
    parameter int STEP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_err,
    output logic              cpu_en,
    input  logic              cpu_halt,
    input  logic              cpu_fetch,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [1:0]        state,
    output logic [1:0]        stop_cause,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic [CYC_W-1:0]  instr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    localparam logic [1:0] c_OP_RUN  = 2'b00;
    localparam logic [1:0] c_OP_STEP = 2'b01;
    localparam logic [1:0] c_OP_STOP = 2'b10;
    localparam logic [1:0] c_OP_LOAD = 2'b11;

    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_USER = 2'b01;
    localparam logic [1:0] c_CAUSE_HALT = 2'b10;
    localparam logic [1:0] c_CAUSE_BP   = 2'b11;

    localparam int                  c_STEP_W    = $clog2(STEP_CYCLES + 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);

    state_t              r_state;
    logic                r_skip_bp;
    logic                r_cmd_err;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_cause;
    logic [CYC_W-1:0]    r_cycle_cnt;
    logic [CYC_W-1:0]    r_instr_cnt;
    logic [c_STEP_W-1:0] r_step_cnt;

    logic w_cmd_ready;
    logic w_accept;
    logic w_bp_hit;
    logic w_cpu_en;

    assign w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept    = cmd_valid & w_cmd_ready;

    // skip_bp masks the breakpoint for the first enabled cycle after a
    // resume so the core can execute the instruction it stopped on.
    assign w_bp_hit = bp_en & cpu_fetch & (cpu_pc == bp_addr) & ~r_skip_bp;

    // Combinational so a HALT or breakpoint freezes the core in the very
    // cycle it is observed rather than one cycle late.
    assign w_cpu_en = ((r_state == ST_RUN)  & ~cpu_halt & ~w_bp_hit) |
                      ((r_state == ST_STEP) & ~cpu_halt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_skip_bp   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_imem_we   <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_cause     <= c_CAUSE_NONE;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_step_cnt  <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            r_imem_we <= 1'b0;

            if (w_cpu_en) begin
                r_skip_bp <= 1'b0;
                if (r_cycle_cnt != '1) begin
                    r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
                end
                if (cpu_fetch && (r_instr_cnt != '1)) begin
                    r_instr_cnt <= r_instr_cnt + CYC_W'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            c_OP_RUN, c_OP_STEP: begin
                                if (cpu_halt) begin
                                    r_cause <= c_CAUSE_HALT;
                                end else begin
                                    r_state    <= (cmd_op == c_OP_RUN) ? ST_RUN : ST_STEP;
                                    r_skip_bp  <= 1'b1;
                                    r_step_cnt <= '0;
                                end
                            end
                            c_OP_LOAD: begin
                                r_state     <= ST_WRITE;
                                r_imem_we   <= 1'b1;
                                r_waddr     <= cmd_addr;
                                r_wdata     <= cmd_data;
                                r_cycle_cnt <= '0;
                                r_instr_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_accept && (cmd_op != c_OP_STOP)) begin
                        r_cmd_err <= 1'b1;
                    end
                    if (cpu_halt) begin
                        r_state <= ST_IDLE;
                        r_cause <= c_CAUSE_HALT;
                    end else if (w_bp_hit) begin
                        r_state <= ST_IDLE;
                        r_cause <= c_CAUSE_BP;
                    end else if (w_accept && (cmd_op == c_OP_STOP)) begin
                        r_state <= ST_IDLE;
                        r_cause <= c_CAUSE_USER;
                    end
                end
                ST_STEP: begin
                    if (cpu_halt) begin
                        r_state <= ST_IDLE;
                        r_cause <= c_CAUSE_HALT;
                    end else if (w_cpu_en) begin
                        if (r_step_cnt == c_STEP_LAST) begin
                            r_state <= ST_IDLE;
                            r_cause <= c_CAUSE_NONE;
                        end else begin
                            r_step_cnt <= r_step_cnt + c_STEP_W'(1);
                        end
                    end
                end
                default: begin
                    // WRITE lasts exactly one cycle; the strobe was set on entry.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign cmd_err    = r_cmd_err;
    assign cpu_en     = w_cpu_en;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign state      = r_state;
    assign stop_cause = r_cause;
    assign cycle_cnt  = r_cycle_cnt;
    assign instr_cnt  = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl: vector table plus
//               hand-written LOAD, STEP, breakpoint, halt, saturation and
//               reset sequences. A small core model advances the PC once per
//               enabled FETCH cycle, alternating FETCH/EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       cpu_halt = 1'b0;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic       cpu_fetch;
    logic [7:0] cpu_pc;

    logic        cmd_ready, cmd_err, cpu_en, imem_we;
    logic [7:0]  imem_waddr, imem_wdata;
    logic [1:0]  state, stop_cause;
    logic [15:0] cycle_cnt, instr_cnt;

    logic        s4_ready, s4_err, s4_en, s4_we;
    logic [7:0]  s4_waddr, s4_wdata;
    logic [1:0]  s4_state, s4_cause;
    logic [3:0]  s4_cycle, s4_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(cmd_err),
        .cpu_en(cpu_en), .cpu_halt(cpu_halt), .cpu_fetch(cpu_fetch), .cpu_pc(cpu_pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .state(state), .stop_cause(stop_cause),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    cpu_run_ctrl #(.CYC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s4_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(s4_err),
        .cpu_en(s4_en), .cpu_halt(cpu_halt), .cpu_fetch(cpu_fetch), .cpu_pc(cpu_pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .imem_we(s4_we), .imem_waddr(s4_waddr),
        .imem_wdata(s4_wdata), .state(s4_state), .stop_cause(s4_cause),
        .cycle_cnt(s4_cycle), .instr_cnt(s4_instr)
    );

    // Core model: FETCH and EXEC alternate on enabled cycles; PC advances
    // at the end of each enabled FETCH.
    logic phase;
    assign cpu_fetch = ~phase;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            cpu_pc <= 8'h00;
        end else if (cpu_en) begin
            phase <= ~phase;
            if (!phase) cpu_pc <= cpu_pc + 8'h01;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cpu_halt  = 1'b0;
        bp_en     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] d;
        logic       h;
        logic [1:0] st;
        logic       rdy;
        logic       we;
        logic       err;
        logic [1:0] cause;
        logic       en;
    } vec_t;

    vec_t tbl [12];

    initial begin
        //            v     op     addr   data   halt  state  rdy   we    err   cause  en
        tbl[0]  = '{1'b1, 2'b11, 8'h05, 8'hA3, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[3]  = '{1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[4]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[5]  = '{1'b1, 2'b11, 8'h11, 8'h22, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
        tbl[6]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[7]  = '{1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
        tbl[8]  = '{1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};

        // Reset state
        #2;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_we", 32'(imem_we), 32'h0);
        chk("rst_en", 32'(cpu_en), 32'h0);
        chk("rst_cycle", 32'(cycle_cnt), 32'h0);
        do_reset();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            cmd_valid = tbl[i].v;
            cmd_op    = tbl[i].op;
            cmd_addr  = tbl[i].a;
            cmd_data  = tbl[i].d;
            cpu_halt  = tbl[i].h;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_we", i), 32'(imem_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_err", i), 32'(cmd_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_cause", i), 32'(stop_cause), 32'(tbl[i].cause));
            chk($sformatf("v%0d_en", i), 32'(cpu_en), 32'(tbl[i].en));
        end
        cmd_valid = 1'b0;
        cpu_halt  = 1'b0;

        // LOAD: one-cycle write strobe, address/data held afterwards
        do_reset();
        issue(2'b11, 8'h05, 8'hA3);
        chk("load_we", 32'(imem_we), 32'h1);
        chk("load_waddr", 32'(imem_waddr), 32'h05);
        chk("load_wdata", 32'(imem_wdata), 32'hA3);
        chk("load_ready", 32'(cmd_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("load_we_off", 32'(imem_we), 32'h0);
        chk("load_waddr_hold", 32'(imem_waddr), 32'h05);
        chk("load_wdata_hold", 32'(imem_wdata), 32'hA3);
        chk("load_idle", 32'(state), 32'h0);

        // Reset while the write strobe is high
        issue(2'b11, 8'h07, 8'h5C);
        chk("rw_we_pre", 32'(imem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rw_we", 32'(imem_we), 32'h0);
        chk("rw_en", 32'(cpu_en), 32'h0);
        chk("rw_state", 32'(state), 32'h0);
        chk("rw_waddr", 32'(imem_waddr), 32'h0);
        chk("rw_cycle", 32'(cycle_cnt), 32'h0);
        do_reset();

        // STEP after a HALT-rejected RUN
        cpu_halt = 1'b1;
        issue(2'b00, 8'h00, 8'h00);
        chk("rej_cause", 32'(stop_cause), 32'h2);
        chk("rej_state", 32'(state), 32'h0);
        cpu_halt = 1'b0;
        issue(2'b01, 8'h00, 8'h00);
        chk("step_state", 32'(state), 32'h2);
        chk("step_ready", 32'(cmd_ready), 32'h0);
        chk("step_first_en", 32'(cpu_en), 32'h1);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (cpu_en) n++;
                @(posedge clk);
                #1;
            end
            chk("step_en_cycles", 32'(n), 32'd2);
        end
        chk("step_cycle_cnt", 32'(cycle_cnt), 32'd2);
        chk("step_instr_cnt", 32'(instr_cnt), 32'd1);
        chk("step_done_state", 32'(state), 32'h0);
        chk("step_done_cause", 32'(stop_cause), 32'h0);

        // Breakpoint at PC 03, then resume past it
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 8'h03;
        issue(2'b00, 8'h00, 8'h00);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (cpu_fetch && cpu_pc == 8'h03) found = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("bp_reached", 32'(found), 32'h1);
        end
        chk("bp_en_low", 32'(cpu_en), 32'h0);
        chk("bp_state_run", 32'(state), 32'h1);
        @(posedge clk);
        #1;
        chk("bp_state_idle", 32'(state), 32'h0);
        chk("bp_cause", 32'(stop_cause), 32'h3);
        chk("bp_pc_hold", 32'(cpu_pc), 32'h03);
        issue(2'b00, 8'h00, 8'h00);
        chk("bp_resume_en", 32'(cpu_en), 32'h1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("bp_resume_pc", 32'(cpu_pc), 32'h05);
        chk("bp_resume_state", 32'(state), 32'h1);
        issue(2'b10, 8'h00, 8'h00);
        chk("bp_stop_cause", 32'(stop_cause), 32'h1);
        bp_en = 1'b0;

        // HALT during RUN gates cpu_en in the same cycle
        do_reset();
        issue(2'b00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        cpu_halt = 1'b1;
        #1;
        chk("halt_en_same", 32'(cpu_en), 32'h0);
        chk("halt_state_run", 32'(state), 32'h1);
        @(posedge clk);
        #1;
        chk("halt_state_idle", 32'(state), 32'h0);
        chk("halt_cause", 32'(stop_cause), 32'h2);
        cpu_halt = 1'b0;

        // Saturation: 20 RUN cycles after a counter-clearing LOAD
        do_reset();
        issue(2'b11, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        issue(2'b00, 8'h00, 8'h00);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("sat_cycle4", 32'(s4_cycle), 32'd15);
        chk("sat_instr4", 32'(s4_instr), 32'd10);
        chk("sat_cycle16", 32'(cycle_cnt), 32'd20);
        chk("sat_instr16", 32'(instr_cnt), 32'd10);
        issue(2'b10, 8'h00, 8'h00);
        chk("sat_stop_state", 32'(state), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
